decode24_strobe: RTL
====================

# decode24_strobe

Registered 2-to-4 one-hot decoder with a valid/ready input handshake and a programmable strobe width. It is the receive-side counterpart to the team's 4-to-2 priority-free encoder. It converts each accepted 2-bit code back into a one-hot strobe on `out`, held for `HOLD` cycles, and signals completion with `done`. Typical use is driving select or enable lines, such as digit or bank selects, from a compact code stream.

## Interface
Parameters:
- `HOLD`, default 4: cycles each one-hot strobe stays asserted; legal range 1..255.

Ports:
- `clk` input, 1 bit: clock, rising edge.
- `rst` input, 1 bit: synchronous reset, active-high.
- `en` input, 1 bit: block enable. Low forces idle and aborts any strobe.
- `in_valid` input, 1 bit: a code is offered.
- `in_ready` output, 1 bit: the block can accept a code this cycle.
- `in` input, 2 bits: code to decode.
- `out` output, 4 bits: one-hot strobe, equal to `4'b0001 << code`; 0 when idle.
- `busy` output, 1 bit: a strobe is in progress (STROBE state).
- `done` output, 1 bit: one-cycle pulse in the last cycle of a completed strobe.

Clock and reset: one clock; reset is synchronous and active-high (`clk`, `rst`).

## Operation
- States: IDLE, STROBE. A down-counter `cnt` is 8 bits wide.
- **Reset:** at a rising edge with `rst`=1, the block goes to IDLE with `out`=0, `busy`=0, `done`=0, `cnt`=0, and the skid buffer empty.
- **Handshake:**
  - `in_ready` = `en` & ~`rst` & (IDLE, or skid slot free when configured).
  - A transfer occurs when `in_valid` & `in_ready` are both high at a rising edge.
  - `in` is sampled only on a transfer.
- **IDLE + transfer:** next state is STROBE, `out` = one-hot(`in`), `cnt` = `HOLD`-1, `busy`=1.
- **STROBE, `cnt`≠0:** `out` is held and `cnt` decrements.
- **STROBE, `cnt`=0:** this is the last strobe cycle and `done`=1 combinationally from state/count. At the next edge:
  - Skid entry pending: reload `out` and `cnt`, stay in STROBE.
  - Otherwise: go to IDLE with `out`=0 and `busy`=0.
- **`en`=0 in STROBE (abort):** at the next edge go to IDLE with `out`=0, discard the skid entry, and no `done` pulse occurs. `done` is gated by `en`.
- **`en`=0 in IDLE:** `in_ready`=0 and nothing is accepted.
- **Invariant:** `out` is always 0 or exactly one-hot; never multi-hot and never X.
- **`HOLD`=1:** each strobe lasts one cycle, and `done` is high in that same cycle.

## Timing
- **Latency:** transfer at edge k gives `out` valid from edge k through edge k+`HOLD` (`HOLD` cycles). `done` is high in the cycle before edge k+`HOLD`.
- **Without skid:** the next transfer is possible no earlier than the edge after the strobe clears, so `out`=0 for at least one cycle between strobes. Throughput is one code per `HOLD`+1 cycles.
- **Simultaneous `rst` and transfer:** reset wins and the code is dropped.
- **Reset mid-strobe:** `out` goes to 0 at that edge, with no `done`.
- **Simultaneous en-fall and last strobe cycle:** abort wins and `done`=0.

## Configuration
- Macro `DECODE24_SKID_EN`.
- **Defined:** adds a one-entry code buffer.
  - In STROBE, `in_ready`=`en` while the buffer is empty.
  - A buffered code launches at the edge after the `cnt`=0 cycle, so `out` switches directly from the old one-hot to the new one-hot with no zero cycle.
  - Sustained throughput is one code per `HOLD` cycles.
  - The buffer is cleared by `rst` and by abort.
- **Undefined:** no buffer; `in_ready`=0 throughout STROBE.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `in_valid`=1 and `in`=2 -> `out`=0, `busy`=0, `done`=0, and no transfer occurs.
- **Single decode, `HOLD`=4:** transfer `in`=3 at edge 0 -> `out`=4'b1000 for edges 0..3, `done` high in the cycle before edge 4, then `out`=0 from edge 4.
- **All codes:** send codes 0,1,2,3 back-to-back with `in_valid` held -> `out` = 0001, 0010, 0100, 1000.
  - Without skid: one zero cycle between strobes and a period of 5 cycles.
  - With `DECODE24_SKID_EN`: no gap and a period of 4 cycles.
- **Abort:** drop `en` 2 cycles into a strobe of `in`=1 -> `out`=0 at the next edge, no `done`, `in_ready`=0 until `en` returns.
- **`HOLD`=1:** stream `in`=2 -> `out`=4'b0100 for 1 cycle per code and `done` pulses every strobe.
- **Skid flush (macro defined):** buffer code 0 during a strobe of code 2, then pulse `rst` -> `out`=0 and code 0 never appears on `out`.

Source files
------------

// File: rtl/decode24_strobe.sv
// Registered 2-to-4 one-hot decoder: valid/ready input, HOLD-cycle strobe on out, done on the last cycle.
// Defining DECODE24_SKID_EN adds a one-entry code buffer so strobes can run back-to-back.
module decode24_strobe #(
    parameter int unsigned HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in,
    output logic [3:0] out,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] RELOAD = 8'(HOLD - 1);

    typedef enum logic {
        IDLE,
        STROBE
    } state_t;

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic [3:0] out_next;
    logic       transfer;

`ifdef DECODE24_SKID_EN
    logic       skid_valid, skid_valid_next;
    logic [1:0] skid_code, skid_code_next;

    assign in_ready = en & ~rst & ((state == IDLE) | ~skid_valid);
`else
    assign in_ready = en & ~rst & (state == IDLE);
`endif

    assign transfer = in_valid & in_ready;
    assign busy     = (state == STROBE);
    assign done     = en & busy & (cnt == '0);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        out_next   = out;
`ifdef DECODE24_SKID_EN
        skid_valid_next = skid_valid;
        skid_code_next  = skid_code;
`endif
        if (!en) begin
            state_next = IDLE;
            cnt_next   = '0;
            out_next   = '0;
`ifdef DECODE24_SKID_EN
            skid_valid_next = 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (transfer) begin
                        state_next = STROBE;
                        out_next   = 4'b0001 << in;
                        cnt_next   = RELOAD;
                    end
                end
                STROBE: begin
                    if (cnt != '0) begin
                        cnt_next = cnt - 8'd1;
`ifdef DECODE24_SKID_EN
                        if (transfer) begin
                            skid_valid_next = 1'b1;
                            skid_code_next  = in;
                        end
`endif
                    end else begin
`ifdef DECODE24_SKID_EN
                        // A code arriving in the last cycle bypasses the empty buffer.
                        if (skid_valid) begin
                            out_next        = 4'b0001 << skid_code;
                            cnt_next        = RELOAD;
                            skid_valid_next = 1'b0;
                        end else if (transfer) begin
                            out_next = 4'b0001 << in;
                            cnt_next = RELOAD;
                        end else begin
                            state_next = IDLE;
                            out_next   = '0;
                        end
`else
                        state_next = IDLE;
                        out_next   = '0;
`endif
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    out_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            out   <= '0;
`ifdef DECODE24_SKID_EN
            skid_valid <= 1'b0;
            skid_code  <= '0;
`endif
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            out   <= out_next;
`ifdef DECODE24_SKID_EN
            skid_valid <= skid_valid_next;
            skid_code  <= skid_code_next;
`endif
        end
    end

endmodule
